draw_obstacle: RTL
==================

// Module: draw_obstacle
// PURPOSE
//  Pixel-pipeline stage between draw_background and MouseDisplay: overlays a square obstacle that bounces
//  inside the arena and flags a hit when the mouse cursor lies inside it. Consumes vga timing + background
//  rgb; re-emits timing delayed to match its own rgb. xpos/ypos are already stable in the pclk domain.
// PARAMETERS
//  MIN_X 361 / MAX_X 661 / MIN_Y 367 / MAX_Y 667 : inclusive arena limits the obstacle must stay within
//  SIZE 32 : obstacle edge length, pixels (SIZE < MAX_X-MIN_X, SIZE < MAX_Y-MIN_Y)
//  SPEED 2 : pixels moved per axis per frame
//  START_X 495 / START_Y 501 : obstacle top-left after reset / on entering RUN
//  OBST_COLOR 12'hF00 / HIT_COLOR 12'hFF0 : fill colour in RUN / in HIT
//  HIT_FRAMES 60 : frames spent in HIT
// PORTS
//  pclk        in  1   pixel clock; all logic on rising edge
//  rst         in  1   synchronous, active-high reset
//  enable      in  1   game running (level)
//  hcount_in   in  12  / vcount_in in 12 : pixel position from draw_background
//  hsync_in, vsync_in, hblnk_in, vblnk_in  in 1 each : timing from draw_background
//  rgb_in      in  12  background colour
//  xpos, ypos  in  12  mouse cursor position
//  hcount_out, vcount_out  out 12 ; hsync_out, vsync_out, hblnk_out, vblnk_out  out 1 : inputs delayed 2 cycles
//  rgb_out     out 12  composed colour, aligned with *_out timing
//  hit_out     out 1   one-cycle pulse on entry to HIT
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; pos=(START_X,START_Y); dir=(+x,+y); hit counter 0.
//  Latency: exactly 2 pclk for every *_out vs *_in, including rgb. Stage1 registers inputs + inside flag;
//   stage2 muxes colour. Pipeline runs in every state.
//  inside = hcount in [x, x+SIZE-1] && vcount in [y, y+SIZE-1] (12-bit unsigned, no wrap).
//  rgb_out: blank (hblnk|vblnk, stage-aligned) -> 12'h000; IDLE -> rgb_in; RUN & inside -> OBST_COLOR;
//   HIT & inside -> HIT_COLOR; else rgb_in.
//  frame_tick: one-cycle pulse on rising edge of vblnk_in (registered prev value). Position, collision check
//   and frame counter update only on frame_tick, so no tearing mid-frame.
//  Movement (RUN, per tick, each axis independent; x shown, y identical):
//   dir +: if x+SIZE-1+SPEED > MAX_X -> x=MAX_X-SIZE+1, dir=- ; else x+=SPEED.
//   dir -: if x < MIN_X+SPEED -> x=MIN_X, dir=+ ; else x-=SPEED. Compare in 13 bits to avoid overflow.
//  Collision (RUN, per tick, using pre-move position): xpos in [x,x+SIZE-1] && ypos in [y,y+SIZE-1].
//  FSM:
//   IDLE: hold pos. enable=1 -> RUN next cycle, pos reloaded to START, dir=(+,+).
//   RUN : tick & collision -> HIT (no move that tick), hit_out=1 for that cycle, counter=0.
//   HIT : pos frozen; counter++ per tick; counter==HIT_FRAMES-1 on tick -> IDLE.
//   Any state, enable=0 -> IDLE next cycle (overrides all; mid-HIT aborts, no further hit_out).
//  Simultaneous: enable falling and collision on same tick -> IDLE, no hit_out.
//  Reset mid-frame: pipeline regs cleared; outputs valid again 2 cycles after rst drops.
// STRUCTURE
//  Shared package game_pkg: arena limits (TOP_V_LINE..RIGHT_H_LINE, BORDER), colour constants,
//   obstacle state enum {IDLE,RUN,HIT}; top-level passes limits as parameters.
//  Sub-module obstacle_mover: pclk,rst,frame_tick,run,load -> x,y,dir; holds bounce arithmetic.
//  draw_obstacle keeps FSM, tick detector, collision compare, 2-stage pixel pipeline.
// TESTING
//  1 Reset, run 3 frames enable=0 -> rgb_out == rgb_in delayed 2 (0 in blank), hit_out never 1.
//  2 enable=1, mouse at (0,0) -> after 1st tick x=497,y=503; pixel (500,510) shows 12'hF00 in next frame.
//  3 Force x=629, dir + (SIZE 32, MAX_X 661) -> next tick x=630, dir -; following tick x=628.
//  4 Mouse at (505,510) with obstacle at (495,501) -> hit_out single pulse on tick, obstacle 12'hFF0
//    for 60 frames, then IDLE (background only).
//  5 In HIT, drop enable after 10 frames -> IDLE next cycle, obstacle not drawn; re-enable -> pos=START.
//  6 Assert rst mid-line for 3 cycles -> all outputs 0 during reset; timing/rgb alignment restored 2 cycles later.

Source files
------------

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game pixel pipeline:
//   - arena limits (inclusive) that the background draws and the obstacle
//     must stay inside, plus the border thickness of the arena frame
//   - colour constants used by the drawing stages
//   - obstacle state enum and per-axis motion record
//   - helper functions for span tests and bounce arithmetic
// ---------------------------------------------------------------------------
package game_pkg;

    // Arena limits, inclusive, in screen pixels
    localparam int LEFT_H_LINE   = 361;
    localparam int RIGHT_H_LINE  = 661;
    localparam int TOP_V_LINE    = 367;
    localparam int BOTTOM_V_LINE = 667;
    localparam int BORDER        = 4;

    // Colours (4:4:4 RGB)
    localparam logic [11:0] OBST_COLOR  = 12'hF00;
    localparam logic [11:0] HIT_COLOR   = 12'hFF0;
    localparam logic [11:0] BLANK_COLOR = 12'h000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } obst_state_e;

    // One axis of obstacle motion: position of the leading (top/left) edge
    // and whether it is currently moving towards larger coordinates.
    typedef struct packed {
        logic [11:0] pos;
        logic        fwd;
    } axis_t;

    // True when v lies in [lo, lo+size-1]. Widened to 13 bits so that an
    // obstacle near the top of the 12-bit range cannot wrap.
    function automatic logic inSpan(input logic [11:0] v,
                                    input logic [11:0] lo,
                                    input int          size);
        logic [12:0] v13;
        logic [12:0] lo13;
        v13  = {1'b0, v};
        lo13 = {1'b0, lo};
        return (v13 >= lo13) && (v13 <= lo13 + 13'(size - 1));
    endfunction

    // Advance one axis by one frame's worth of motion, bouncing off the
    // inclusive limits lo/hi. On a bounce the obstacle is snapped flush to
    // the wall rather than overshooting, and the direction flips.
    function automatic axis_t bounceStep(input axis_t a,
                                         input int    lo,
                                         input int    hi,
                                         input int    size,
                                         input int    speed);
        axis_t       r;
        logic [12:0] p;
        r = a;
        p = {1'b0, a.pos};
        if (a.fwd) begin
            if (p + 13'(size - 1 + speed) > 13'(hi)) begin
                r.pos = 12'(hi - size + 1);
                r.fwd = 1'b0;
            end else begin
                r.pos = a.pos + 12'(speed);
            end
        end else begin
            if (p < 13'(lo + speed)) begin
                r.pos = 12'(lo);
                r.fwd = 1'b1;
            end else begin
                r.pos = a.pos - 12'(speed);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/obstacle_mover.sv
// ---------------------------------------------------------------------------
// obstacle_mover
// Holds the obstacle top-left position and direction, and applies the
// per-frame bounce motion on both axes independently.
// Ports:
//   pclk, rst   pixel clock, synchronous active-high reset
//   frame_tick  one-cycle pulse at the start of vertical blanking
//   run         move on this frame tick (FSM has qualified state/collision)
//   load        reload the start position, direction (+x,+y)
//   x, y        current obstacle top-left corner
// ---------------------------------------------------------------------------
module obstacle_mover
    import game_pkg::*;
#(
    parameter int MIN_X   = LEFT_H_LINE,
    parameter int MAX_X   = RIGHT_H_LINE,
    parameter int MIN_Y   = TOP_V_LINE,
    parameter int MAX_Y   = BOTTOM_V_LINE,
    parameter int SIZE    = 32,
    parameter int SPEED   = 2,
    parameter int START_X = 495,
    parameter int START_Y = 501
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        run,
    input  logic        load,
    output logic [11:0] x,
    output logic [11:0] y
);

    localparam axis_t START_AX = '{pos: 12'(START_X), fwd: 1'b1};
    localparam axis_t START_AY = '{pos: 12'(START_Y), fwd: 1'b1};

    axis_t xAxis_q, xAxis_d;
    axis_t yAxis_q, yAxis_d;

    // Next position: a load wins over motion so entering RUN always starts
    // from the same spot; otherwise move only on a qualified frame tick.
    always_comb begin
        xAxis_d = xAxis_q;
        yAxis_d = yAxis_q;
        if (load) begin
            xAxis_d = START_AX;
            yAxis_d = START_AY;
        end else if (run && frame_tick) begin
            xAxis_d = bounceStep(xAxis_q, MIN_X, MAX_X, SIZE, SPEED);
            yAxis_d = bounceStep(yAxis_q, MIN_Y, MAX_Y, SIZE, SPEED);
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            xAxis_q <= START_AX;
            yAxis_q <= START_AY;
        end else begin
            xAxis_q <= xAxis_d;
            yAxis_q <= yAxis_d;
        end
    end

    assign x = xAxis_q.pos;
    assign y = yAxis_q.pos;

endmodule

// File: rtl/draw_obstacle.sv
// ---------------------------------------------------------------------------
// draw_obstacle
// Pixel-pipeline stage that overlays a bouncing square obstacle on the
// background and reports when the mouse cursor lands inside it.
// Ports:
//   pclk, rst                 pixel clock, synchronous active-high reset
//   enable                    game running (level)
//   hcount_in, vcount_in      pixel position from the previous stage
//   hsync_in..vblnk_in        timing from the previous stage
//   rgb_in                    background colour
//   xpos, ypos                mouse cursor position (pclk domain)
//   hcount_out..vblnk_out     timing delayed by two pixel clocks
//   rgb_out                   composed colour aligned with the *_out timing
//   hit_out                   one-cycle pulse on entering HIT
// ---------------------------------------------------------------------------
module draw_obstacle
    import game_pkg::*;
#(
    parameter int          MIN_X      = LEFT_H_LINE,
    parameter int          MAX_X      = RIGHT_H_LINE,
    parameter int          MIN_Y      = TOP_V_LINE,
    parameter int          MAX_Y      = BOTTOM_V_LINE,
    parameter int          SIZE       = 32,
    parameter int          SPEED      = 2,
    parameter int          START_X    = 495,
    parameter int          START_Y    = 501,
    parameter logic [11:0] OBST_COL   = OBST_COLOR,
    parameter logic [11:0] HIT_COL    = HIT_COLOR,
    parameter int          HIT_FRAMES = 60
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic [11:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic        hit_out
);

    localparam int CNT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

    obst_state_e      state_q, state_d;
    logic [CNT_W-1:0] hitCnt_q, hitCnt_d;
    logic             hitOut_q, hitOut_d;
    logic             vblnkPrev_q;
    logic             frameTick;
    logic             insideNow;
    logic             collision;
    logic             loadPos;
    logic             movePos;
    logic [11:0]      obstX, obstY;

    // Stage 1 and stage 2 pipeline registers
    logic [11:0] hcountS1_q, vcountS1_q, rgbS1_q;
    logic        hsyncS1_q, vsyncS1_q, hblnkS1_q, vblnkS1_q, insideS1_q;
    logic [11:0] hcountS2_q, vcountS2_q, rgbS2_q, rgbS2_d;
    logic        hsyncS2_q, vsyncS2_q, hblnkS2_q, vblnkS2_q;

    // Updates happen once per frame, at the start of vertical blanking, so
    // the obstacle never moves while it is being scanned out.
    assign frameTick = vblnk_in & ~vblnkPrev_q;
    assign insideNow = inSpan(hcount_in, obstX, SIZE) && inSpan(vcount_in, obstY, SIZE);
    assign collision = inSpan(xpos, obstX, SIZE) && inSpan(ypos, obstY, SIZE);

    obstacle_mover #(
        .MIN_X   (MIN_X),
        .MAX_X   (MAX_X),
        .MIN_Y   (MIN_Y),
        .MAX_Y   (MAX_Y),
        .SIZE    (SIZE),
        .SPEED   (SPEED),
        .START_X (START_X),
        .START_Y (START_Y)
    ) u_mover (
        .pclk       (pclk),
        .rst        (rst),
        .frame_tick (frameTick),
        .run        (movePos),
        .load       (loadPos),
        .x          (obstX),
        .y          (obstY)
    );

    // Game FSM. Dropping enable always returns to IDLE, which also cancels a
    // hit that coincides with that tick. A collision tick freezes the
    // obstacle, so it stays where the mouse caught it for the whole HIT.
    always_comb begin
        state_d  = state_q;
        hitCnt_d = hitCnt_q;
        hitOut_d = 1'b0;
        loadPos  = 1'b0;
        movePos  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                    loadPos = 1'b1;
                end
                RUN: begin
                    if (frameTick) begin
                        if (collision) begin
                            state_d  = HIT;
                            hitCnt_d = '0;
                            hitOut_d = 1'b1;
                        end else begin
                            movePos = 1'b1;
                        end
                    end
                end
                HIT: begin
                    if (frameTick) begin
                        if (hitCnt_q == CNT_W'(HIT_FRAMES - 1)) begin
                            state_d = IDLE;
                        end else begin
                            hitCnt_d = hitCnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= IDLE;
            hitCnt_q    <= '0;
            hitOut_q    <= 1'b0;
            vblnkPrev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hitCnt_q    <= hitCnt_d;
            hitOut_q    <= hitOut_d;
            vblnkPrev_q <= vblnk_in;
        end
    end

    // Stage-2 colour choice: blanking always forces black; the obstacle is
    // only painted outside IDLE, in a colour that tells RUN from HIT.
    always_comb begin
        rgbS2_d = rgbS1_q;
        if (hblnkS1_q || vblnkS1_q) begin
            rgbS2_d = BLANK_COLOR;
        end else if (insideS1_q) begin
            if (state_q == RUN) begin
                rgbS2_d = OBST_COL;
            end else if (state_q == HIT) begin
                rgbS2_d = HIT_COL;
            end
        end
    end

    // Two-stage pixel pipeline, running in every state so timing and colour
    // stay aligned regardless of what the game is doing.
    always_ff @(posedge pclk) begin
        if (rst) begin
            hcountS1_q <= '0;
            vcountS1_q <= '0;
            hsyncS1_q  <= 1'b0;
            vsyncS1_q  <= 1'b0;
            hblnkS1_q  <= 1'b0;
            vblnkS1_q  <= 1'b0;
            rgbS1_q    <= '0;
            insideS1_q <= 1'b0;
            hcountS2_q <= '0;
            vcountS2_q <= '0;
            hsyncS2_q  <= 1'b0;
            vsyncS2_q  <= 1'b0;
            hblnkS2_q  <= 1'b0;
            vblnkS2_q  <= 1'b0;
            rgbS2_q    <= '0;
        end else begin
            hcountS1_q <= hcount_in;
            vcountS1_q <= vcount_in;
            hsyncS1_q  <= hsync_in;
            vsyncS1_q  <= vsync_in;
            hblnkS1_q  <= hblnk_in;
            vblnkS1_q  <= vblnk_in;
            rgbS1_q    <= rgb_in;
            insideS1_q <= insideNow;
            hcountS2_q <= hcountS1_q;
            vcountS2_q <= vcountS1_q;
            hsyncS2_q  <= hsyncS1_q;
            vsyncS2_q  <= vsyncS1_q;
            hblnkS2_q  <= hblnkS1_q;
            vblnkS2_q  <= vblnkS1_q;
            rgbS2_q    <= rgbS2_d;
        end
    end

    assign hcount_out = hcountS2_q;
    assign vcount_out = vcountS2_q;
    assign hsync_out  = hsyncS2_q;
    assign vsync_out  = vsyncS2_q;
    assign hblnk_out  = hblnkS2_q;
    assign vblnk_out  = vblnkS2_q;
    assign rgb_out    = rgbS2_q;
    assign hit_out    = hitOut_q;

endmodule
